key_repeat: RTL



---
 rtl/key_repeat.sv | 139 +++++++++++++
 1 files changed

// File: rtl/key_repeat.sv
// key_repeat: per-key press pulse plus delayed auto-shift repeat, timed in tick strobes.
// Optional macro KEY_REPEAT_RELEASE_EN adds key_release, a one-clk pulse when a held key is let go.
module key_repeat #(
    parameter int unsigned N_KEYS     = 4,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned DAS_DELAY  = 16,
    parameter int unsigned ARR_PERIOD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              enable,
    input  logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_event,
`ifdef KEY_REPEAT_RELEASE_EN
    output logic [N_KEYS-1:0] key_held,
    output logic [N_KEYS-1:0] key_release
`else
    output logic [N_KEYS-1:0] key_held
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] DAS_LAST = CNT_W'(DAS_DELAY - 1);
    localparam logic [CNT_W-1:0] ARR_LAST = CNT_W'(ARR_PERIOD - 1);

    state_e            state_q [N_KEYS];
    state_e            state_d [N_KEYS];
    logic [CNT_W-1:0]  cnt_q   [N_KEYS];
    logic [CNT_W-1:0]  cnt_d   [N_KEYS];
    logic [N_KEYS-1:0] key_prev_q;
    logic [N_KEYS-1:0] event_q;
    logic [N_KEYS-1:0] event_d;
`ifdef KEY_REPEAT_RELEASE_EN
    logic [N_KEYS-1:0] release_q;
    logic [N_KEYS-1:0] release_d;
`endif

    // State, counter and event registers; key_prev tracks key_level regardless of enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < N_KEYS; k++) begin
                state_q[k] <= S_IDLE;
                cnt_q[k]   <= '0;
            end
            key_prev_q <= '1;
            event_q    <= '0;
`ifdef KEY_REPEAT_RELEASE_EN
            release_q  <= '0;
`endif
        end else begin
            for (int unsigned k = 0; k < N_KEYS; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
            key_prev_q <= key_level;
            event_q    <= event_d;
`ifdef KEY_REPEAT_RELEASE_EN
            release_q  <= release_d;
`endif
        end
    end

    // Per-key next state: disable beats release, release beats tick, tick drives delay/repeat counting.
    always_comb begin
        event_d = '0;
`ifdef KEY_REPEAT_RELEASE_EN
        release_d = '0;
`endif
        for (int unsigned k = 0; k < N_KEYS; k++) begin
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
            if (!enable) begin
                state_d[k] = S_IDLE;
                cnt_d[k]   = '0;
            end else if ((state_q[k] != S_IDLE) && !key_level[k]) begin
                state_d[k] = S_IDLE;
                cnt_d[k]   = '0;
`ifdef KEY_REPEAT_RELEASE_EN
                release_d[k] = 1'b1;
`endif
            end else begin
                case (state_q[k])
                    S_IDLE: begin
                        if (key_level[k] && !key_prev_q[k]) begin
                            event_d[k] = 1'b1;
                            state_d[k] = S_DELAY;
                            cnt_d[k]   = '0;
                        end
                    end
                    S_DELAY: begin
                        if (tick) begin
                            if (cnt_q[k] == DAS_LAST) begin
                                event_d[k] = 1'b1;
                                state_d[k] = S_REPEAT;
                                cnt_d[k]   = '0;
                            end else begin
                                cnt_d[k] = cnt_q[k] + CNT_W'(1);
                            end
                        end
                    end
                    S_REPEAT: begin
                        if (tick) begin
                            if (cnt_q[k] == ARR_LAST) begin
                                event_d[k] = 1'b1;
                                cnt_d[k]   = '0;
                            end else begin
                                cnt_d[k] = cnt_q[k] + CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_d[k] = S_IDLE;
                        cnt_d[k]   = '0;
                    end
                endcase
            end
        end
    end

    // Held flag is a direct decode of the registered state, so it rises with the press pulse.
    always_comb begin
        key_held = '0;
        for (int unsigned k = 0; k < N_KEYS; k++) begin
            key_held[k] = (state_q[k] != S_IDLE);
        end
    end

    assign key_event = event_q;
`ifdef KEY_REPEAT_RELEASE_EN
    assign key_release = release_q;
`endif

endmodule
